// File: rtl/aes_defines.sv
// Shared AES constants and the one-hot framing state used by the cipher front end.
package aes_defines;

  localparam int AES_BLOCK_SIZE  = 128;
  localparam int AES128_KEY_SIZE = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    ST_KEY = 3'b001,
    ST_MSG = 3'b010,
    ST_PAD = 3'b100
  } state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle carrying byte-granular data with tkeep and tlast.
interface axis_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/aes_pkcs7_byte_fill.sv
// Replaces every byte at index k and above with the PKCS#7 pad value.
module aes_pkcs7_byte_fill #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       k,
  input  logic [7:0]       pad,
  output logic [WIDTH-1:0] filled
);

  always_comb begin
    for (int i = 0; i < WIDTH / 8; i++) begin
      filled[8*i +: 8] = (5'(i) < k) ? data[8*i +: 8] : pad;
    end
  end

endmodule

// File: rtl/aes_pkcs7_padder.sv
// Frames key + byte-granular plaintext into whole 128-bit blocks with PKCS#7 padding
// for the AES-128 ECB cores, behind a single output register.
module aes_pkcs7_padder
  import aes_defines::*;
#(
  parameter int AXIS_WIDTH = 32
) (
  input logic   Clk,
  input logic   Rst_n,
  axis_if.slave  S_axis,
  axis_if.master M_axis
);

  localparam int NB          = AXIS_WIDTH / 8;
  localparam int KEY_BEATS   = AES128_KEY_SIZE / AXIS_WIDTH;
  localparam int BLOCK_BEATS = AES_BLOCK_SIZE / AXIS_WIDTH;
  localparam int CW          = $clog2(KEY_BEATS) + 1;

  state_t                state, state_n;
  logic [CW-1:0]         beat_cnt, beat_cnt_n;
  logic [3:0]            blk_cnt, blk_cnt_n;
  logic [7:0]            pad_q, pad_n;
  logic [AXIS_WIDTH-1:0] tdata_q, tdata_n;
  logic                  tvalid_q, tvalid_n;
  logic                  tlast_q, tlast_n;

  logic                  load;
  logic                  run;
  logic [4:0]            k;
  logic [3:0]            total;
  logic [3:0]            gap;
  logic [7:0]            pad_val;
  logic [CW-1:0]         r_beats;
  logic [AXIS_WIDTH-1:0] filled;

  assign load = ~tvalid_q | M_axis.tready;

  assign S_axis.tready = Rst_n & ((state == ST_KEY) | (state == ST_MSG)) & load;

  assign M_axis.tdata  = tdata_q;
  assign M_axis.tkeep  = {NB{tvalid_q}};
  assign M_axis.tlast  = tlast_q;
  assign M_axis.tvalid = tvalid_q;

  // Valid byte count stops at the first cleared tkeep bit; anything above it is dropped.
  always_comb begin
    k   = '0;
    run = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (run && S_axis.tkeep[i]) k = k + 5'd1;
      else                        run = 1'b0;
    end
  end

  // Pad beats left after the last beat: fill to the block boundary, or a whole
  // extra block when the message already ends exactly on one.
  always_comb begin
    total   = blk_cnt + k[3:0];
    pad_val = 8'(AES_BLOCK_BYTES) - {4'd0, total};
    gap     = 4'd0 - (blk_cnt + 4'(NB));
    if (total == 4'd0 && k == 5'(NB)) r_beats = CW'(BLOCK_BEATS);
    else                              r_beats = CW'(int'(gap) / NB);
  end

  aes_pkcs7_byte_fill #(.WIDTH(AXIS_WIDTH)) u_fill (
    .data   (S_axis.tdata),
    .k      (k),
    .pad    (pad_val),
    .filled (filled)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    blk_cnt_n  = blk_cnt;
    pad_n      = pad_q;
    tdata_n    = tdata_q;
    tvalid_n   = tvalid_q;
    tlast_n    = tlast_q;
    if (load) begin
      tvalid_n = 1'b0;
      tlast_n  = 1'b0;
      case (state)
        ST_KEY: if (S_axis.tvalid) begin
          tvalid_n = 1'b1;
          tdata_n  = S_axis.tdata;
          if (beat_cnt == '0) begin
            state_n   = ST_MSG;
            blk_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt - CW'(1);
          end
        end
        ST_MSG: if (S_axis.tvalid) begin
          tvalid_n = 1'b1;
          if (!S_axis.tlast) begin
            tdata_n   = S_axis.tdata;
            blk_cnt_n = blk_cnt + 4'(NB);
          end else begin
            tdata_n = filled;
            if (r_beats == '0) begin
              tlast_n    = 1'b1;
              state_n    = ST_KEY;
              beat_cnt_n = CW'(KEY_BEATS - 1);
            end else begin
              pad_n      = pad_val;
              beat_cnt_n = r_beats - CW'(1);
              state_n    = ST_PAD;
            end
          end
        end
        ST_PAD: begin
          tvalid_n = 1'b1;
          tdata_n  = {NB{pad_q}};
          if (beat_cnt == '0) begin
            tlast_n    = 1'b1;
            state_n    = ST_KEY;
            beat_cnt_n = CW'(KEY_BEATS - 1);
          end else begin
            beat_cnt_n = beat_cnt - CW'(1);
          end
        end
        default: state_n = ST_KEY;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_KEY;
      beat_cnt <= CW'(KEY_BEATS - 1);
      blk_cnt  <= '0;
      pad_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      blk_cnt  <= blk_cnt_n;
      pad_q    <= pad_n;
      tdata_q  <= tdata_n;
      tvalid_q <= tvalid_n;
      tlast_q  <= tlast_n;
    end
  end

endmodule

// File: doc/aes_pkcs7_padder.md
Name: aes_pkcs7_padder

Overview:
- Upstream framing stage for the AES-128 ECB cores.
- Accepts one AXI-Stream per message: the key first, then a byte-granular plaintext stream ending in tlast with a partial tkeep.
- Emits the word-aligned stream the cipher core consumes: key beats, then whole 128-bit plaintext blocks with PKCS#7 padding appended, tlast on the final beat of the final block.

Parameters:
AXIS_WIDTH, 32, data width of both streams in bits; legal values 32, 64, 128 (divides 128).

Ports:
Clk  input  1  clock
Rst_n  input  1  synchronous active-low reset
S_axis  axis_if.slave  AXIS_WIDTH  key and message input (tdata, tkeep, tlast, tvalid, tready)
M_axis  axis_if.master  AXIS_WIDTH  key and padded plaintext output, same signals

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous, active-low, on Rst_n.
- Reset values:
  - M_axis.tvalid=0, tlast=0, tdata=0, tkeep=0; S_axis.tready=0 during reset.
  - State=ST_KEY, beat counter = KEY_BEATS-1 (KEY_BEATS = 128/AXIS_WIDTH), block byte counter=0.
- Byte order: byte i of a beat is tdata[8i+7:8i]. The first byte of the message is byte 0 of the first message beat. This matches the cipher core, which shifts the first beat into the LSBs.
- Output stage: single output register, 1-cycle latency.
  - Load when ~M_axis.tvalid | M_axis.tready.
  - S_axis.tready = (state is ST_KEY or ST_MSG) & (~M_axis.tvalid | M_axis.tready).
  - M_axis.tkeep is always all-ones when tvalid=1.
  - Output holds stable while tvalid & ~tready.
- ST_KEY:
  - Pass KEY_BEATS input beats unchanged; output tlast=0.
  - Input tlast and tkeep are ignored here.
  - After the last key beat -> ST_MSG; block byte counter=0.
- ST_MSG, non-last beat (tlast=0):
  - Pass through unchanged; tkeep treated as all-ones.
  - Block byte counter += AXIS_WIDTH/8, modulo 16.
- ST_MSG, last beat (tlast=1):
  - k = number of contiguous ones in tkeep from bit 0 (0..AXIS_WIDTH/8). Bytes at and above the first zero are discarded.
  - total = (block byte counter + k) mod 16; pad = 16 - total (range 1..16, 8-bit value).
  - Output beat: bytes 0..k-1 from input; bytes k..top replaced by pad.
  - Remaining pad beats R:
    - if total==0 and k==AXIS_WIDTH/8: R = 128/AXIS_WIDTH (one full extra block of 0x10).
    - otherwise: R = (16 - ((block byte counter + AXIS_WIDTH/8) mod 16)) mod 16, divided by AXIS_WIDTH/8.
  - If R==0: output tlast=1, next state ST_KEY. Else latch pad, load pad-beat counter=R-1, output tlast=0, next state ST_PAD.
- ST_PAD:
  - S_axis.tready=0.
  - Emit beats with every byte = latched pad, one per accepted output slot.
  - tlast=1 on the beat loaded while pad-beat counter==0; that load -> ST_KEY.
- Back-pressure:
  - M_axis.tready low for any number of cycles must not drop, duplicate or reorder beats.
  - Input acceptance and output load occur on the same edge (no bubble at tready=1).
- Reset mid-operation: returns to ST_KEY. Output tvalid drops on the next edge and the partial frame is discarded. The next beat accepted is key beat 0.
- Invariant: the number of message output beats is always a multiple of 128/AXIS_WIDTH and always greater than 0.

Decomposition:
- Shared package (aes_defines): AES_BLOCK_SIZE, AES128_KEY_SIZE, AES_BLOCK_BYTES=16, and the state enum {ST_KEY, ST_MSG, ST_PAD} as one-hot 3-bit.
- One sub-module: aes_pkcs7_byte_fill (combinational). Inputs: data, k, pad. Output: the data with bytes k..top replaced by pad. Instantiated once in the last-beat path.

Test Plan (AXIS_WIDTH=32, key 000102..0f):
- 4 key beats + 3 message beats, last tkeep=4'b0011 (10 bytes) -> 4 key beats, then block bytes 0..9 from input and bytes 10..15 = 0x06; tlast on beat 4 of the block.
- 16-byte message, last tkeep=4'b1111 -> data block unchanged, then 4 beats of 32'h10101010; tlast only on the 8th message beat.
- Single beat with tlast=1, tkeep=4'b0000 -> 4 beats 32'h10101010, tlast on beat 4; tready low during ST_PAD.
- Two back-to-back messages (5 bytes, then 15 bytes), M_axis.tready toggled 1010 pseudo-randomly -> first block padded with 0x0b, second with 0x01. Each frame preceded by its 4 key beats; output identical to the tready=1 run.
- Rst_n low for 1 cycle after key beat 2 of a frame, then a full frame of 4 bytes -> tvalid=0 the cycle after reset; next output is key beat 0 of the new frame, followed by a block padded with 0x0c.
- Non-contiguous last tkeep=4'b1101 -> k=1; bytes 1..3 = pad 0x0f; total output is one block.
